// File: rtl/wb_arbiter2_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arbiter2_pkg;

    // Arbiter grant state; StAbort is only entered when the timeout feature is built in.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGnt0  = 2'd1,
        StGnt1  = 2'd2,
        StAbort = 2'd3
    } arb_state_e;

    // Index of a requesting master (0 = instruction bus, 1 = data bus).
    typedef logic mst_idx_t;

    // Bits needed to hold values 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle, 32-bit address/data with byte selects.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, sel, adr, dat_m,
        input  dat_s, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_m,
        output dat_s, ack, err, stall
    );
endinterface

// File: rtl/wb_arb_rr2.sv
// Two-requester round-robin picker: on a tie the requester that was not granted last wins.
module wb_arb_rr2
    import wb_arbiter2_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_idx_t   last_grant_i,
    output mst_idx_t   grant_o,
    output logic       valid_o
);

    // Pick the single requester, or alternate away from the last winner on a tie.
    always_comb begin
        valid_o = |req_i;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter with bus-cycle granular
// round-robin grants and outstanding-transfer tracking.
// Optional feature macro: WB_ARB_TIMEOUT_EN (hung-slave timeout and ABORT state).
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 256
) (
    input  logic clk,
    input  logic rst_n,
    wb_if.slave  m0_wb,
    wb_if.slave  m1_wb,
    wb_if.master s_wb
);

    localparam int unsigned    CntW   = cnt_width(MaxOutstanding);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    if (MaxOutstanding == 0 || TimeoutCycles == 0) begin : g_bad_cfg
        $error("wb_arbiter2: MaxOutstanding and TimeoutCycles must be non-zero");
    end

    arb_state_e      state_q, state_d;
    mst_idx_t        last_grant_q, last_grant_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;

    mst_idx_t    rr_grant;
    logic        rr_valid;

    mst_idx_t    own_idx;
    logic        own_cyc, own_stb, own_we;
    logic [3:0]  own_sel;
    logic [31:0] own_adr, own_dat_m;

    logic granted, at_limit, stall_own, accept, resp, dec, timeout;

    wb_arb_rr2 u_rr (
        .req_i        ({m1_wb.cyc, m0_wb.cyc}),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .valid_o      (rr_valid)
    );

    // Select the bus of the current/last owner; last_grant_q always names it.
    always_comb begin
        own_idx = last_grant_q;
        if (own_idx) begin
            own_cyc   = m1_wb.cyc;
            own_stb   = m1_wb.stb;
            own_we    = m1_wb.we;
            own_sel   = m1_wb.sel;
            own_adr   = m1_wb.adr;
            own_dat_m = m1_wb.dat_m;
        end else begin
            own_cyc   = m0_wb.cyc;
            own_stb   = m0_wb.stb;
            own_we    = m0_wb.we;
            own_sel   = m0_wb.sel;
            own_adr   = m0_wb.adr;
            own_dat_m = m0_wb.dat_m;
        end
    end

    // Handshake qualifiers shared by the slave mux, master mux and counter.
    always_comb begin
        granted   = (state_q == StGnt0) || (state_q == StGnt1);
        at_limit  = (outstanding_q == CntMax);
        stall_own = s_wb.stall | at_limit | timeout;
        // stb is withheld at the limit so the slave never accepts what the master saw stalled
        accept    = granted & own_cyc & own_stb & ~at_limit & ~timeout & ~s_wb.stall;
        resp      = granted & own_cyc & (s_wb.ack | s_wb.err);
        dec       = resp & (outstanding_q != '0);
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TmrW = cnt_width(TimeoutCycles);

    logic [TmrW-1:0] timer_q, timer_d;
    logic            tmr_en;

    // Count response-less cycles while transfers are pending; any response clears it.
    always_comb begin
        tmr_en  = granted & own_cyc & (outstanding_q != '0) & ~(s_wb.ack | s_wb.err);
        timer_d = tmr_en ? timer_q + 1'b1 : '0;
        timeout = tmr_en & (timer_q == TmrW'(TimeoutCycles - 1));
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Slave port: combinational copy of the owner while granted, idle otherwise.
    always_comb begin
        s_wb.cyc   = 1'b0;
        s_wb.stb   = 1'b0;
        s_wb.we    = 1'b0;
        s_wb.sel   = '0;
        s_wb.adr   = '0;
        s_wb.dat_m = '0;
        if (granted) begin
            s_wb.cyc   = own_cyc & ~timeout;
            s_wb.stb   = own_cyc & own_stb & ~at_limit & ~timeout;
            s_wb.we    = own_we;
            s_wb.sel   = own_sel;
            s_wb.adr   = own_adr;
            s_wb.dat_m = own_dat_m;
        end
    end

    // Master ports: only the granted owner sees responses; everyone else is stalled.
    always_comb begin
        m0_wb.dat_s = s_wb.dat_s;
        m0_wb.ack   = 1'b0;
        m0_wb.err   = 1'b0;
        m0_wb.stall = 1'b1;
        m1_wb.dat_s = s_wb.dat_s;
        m1_wb.ack   = 1'b0;
        m1_wb.err   = 1'b0;
        m1_wb.stall = 1'b1;
        if (granted) begin
            if (own_idx) begin
                m1_wb.ack   = resp & s_wb.ack;
                m1_wb.err   = (resp & s_wb.err) | timeout;
                m1_wb.stall = stall_own;
            end else begin
                m0_wb.ack   = resp & s_wb.ack;
                m0_wb.err   = (resp & s_wb.err) | timeout;
                m0_wb.stall = stall_own;
            end
        end
    end

    // Next grant state, round-robin history and outstanding count.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        outstanding_d = outstanding_q;
        unique case (state_q)
            StIdle: begin
                if (rr_valid) begin
                    state_d      = rr_grant ? StGnt1 : StGnt0;
                    last_grant_d = rr_grant;
                end
            end
            StGnt0, StGnt1: begin
                if (!own_cyc) begin
                    // Release (or master abort): late slave responses are dropped.
                    state_d       = StIdle;
                    outstanding_d = '0;
                end else if (timeout) begin
                    state_d       = StAbort;
                    outstanding_d = '0;
                end else begin
                    outstanding_d = outstanding_q + CntW'(accept) - CntW'(dec);
                end
            end
            StAbort: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2 (MaxOutstanding=4, TimeoutCycles=16).
module tb_wb_arbiter2;
    import wb_arbiter2_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] pipe;
    bit         auto_ack;

    always #5 clk = ~clk;

    wb_if m0 ();
    wb_if m1 ();
    wb_if s ();

    wb_arbiter2 #(
        .MaxOutstanding (4),
        .TimeoutCycles  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0_wb (m0),
        .m1_wb (m1),
        .s_wb  (s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; slave model acks 4 windows
    // after an accept (3 full waiting cycles in between) when auto_ack is set.
    task automatic tick();
        logic acc;
        acc = s.cyc & s.stb & ~s.stall;
        @(posedge clk);
        #1;
        pipe = {pipe[6:0], acc};
        if (auto_ack) begin
            s.ack   = pipe[3];
            s.dat_s = 32'hCAFE_0000;
        end
    endtask

    task automatic idle_all();
        m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.sel = 0; m0.adr = 0; m0.dat_m = 0;
        m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.sel = 0; m1.adr = 0; m1.dat_m = 0;
        s.ack = 0; s.err = 0; s.stall = 0; s.dat_s = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        auto_ack = 0;
        pipe = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int owner, sent, acks, m0_acks, peak, first_stall, stall_cnt, fwd, err_cnt, err_first;

        do_reset();
        #1;
        check("rst_s_cyc", s.cyc, 0);
        check("rst_s_stb", s.stb, 0);
        check("rst_s_adr", s.adr, 0);
        check("rst_m0_stall", m0.stall, 1);
        check("rst_m1_stall", m1.stall, 1);
        check("rst_m0_ack", m0.ack, 0);
        check("rst_outst", dut.outstanding_q, 0);
        check("rst_last_grant", dut.last_grant_q, 1);

        // m0 single read
        m0.cyc = 1; m0.stb = 1; m0.adr = 32'h80; m0.sel = 4'hF;
        #1;
        check("t1_c0_s_cyc", s.cyc, 0);
        check("t1_c0_m0_stall", m0.stall, 1);
        tick(); #1;
        check("t1_c1_s_stb", s.stb, 1);
        check("t1_c1_s_adr", s.adr, 32'h80);
        check("t1_c1_m0_stall", m0.stall, 0);
        check("t1_c1_m1_stall", m1.stall, 1);
        tick();
        m0.stb = 0; s.ack = 1; s.dat_s = 32'h13;
        #1;
        check("t1_c2_m0_ack", m0.ack, 1);
        check("t1_c2_m0_dat", m0.dat_s, 32'h13);
        check("t1_c2_m1_ack", m1.ack, 0);
        check("t1_c2_m1_stall", m1.stall, 1);
        tick();
        m0.cyc = 0; s.ack = 0;
        #1;
        check("t1_c3_s_cyc", s.cyc, 0);
        tick(); #1;
        check("t1_c4_state", dut.state_q, StIdle);
        check("t1_c4_outst", dut.outstanding_q, 0);

        // ack and err together: both forwarded, counter drops by one
        m0.cyc = 1; m0.stb = 1; m0.adr = 32'h84;
        tick();
        tick();
        m0.stb = 0; s.ack = 1; s.err = 1;
        #1;
        check("ae_m0_ack", m0.ack, 1);
        check("ae_m0_err", m0.err, 1);
        tick();
        s.ack = 0; s.err = 0;
        #1;
        check("ae_outst", dut.outstanding_q, 0);
        m0.cyc = 0;
        tick();

        // round-robin alternation with continuous requesters
        do_reset();
        m0.adr = 32'h100; m1.adr = 32'h200;
        m0.cyc = 1; m1.cyc = 1;
        for (int i = 0; i < 4; i++) begin
            owner = i % 2;
            tick(); #1;
            check($sformatf("rr%0d_adr", i), s.adr, (owner == 1) ? 32'h200 : 32'h100);
            check($sformatf("rr%0d_m0_stall", i), m0.stall, (owner == 1) ? 1 : 0);
            check($sformatf("rr%0d_m1_stall", i), m1.stall, (owner == 1) ? 0 : 1);
            if (owner == 1) m1.cyc = 0; else m0.cyc = 0;
            tick();
            if (owner == 1) m1.cyc = 1; else m0.cyc = 1;
            #1;
            check($sformatf("rr%0d_dead_cyc", i), s.cyc, 0);
        end
        m0.cyc = 0; m1.cyc = 0;
        tick();

        // m1 six pipelined writes against the outstanding limit
        auto_ack = 1; pipe = '0;
        sent = 0; acks = 0; m0_acks = 0; peak = 0; first_stall = -1; stall_cnt = 0;
        m1.cyc = 1; m1.we = 1; m1.sel = 4'hF;
        m1.stb = 1; m1.adr = 32'h1000; m1.dat_m = 32'hD0;
        tick();
        for (int k = 0; k < 40 && acks < 6; k++) begin
            m1.stb = (sent < 6);
            m1.adr = 32'h1000 + 32'(4 * sent);
            m1.dat_m = 32'hD0 + 32'(sent);
            #1;
            if (int'(dut.outstanding_q) > peak) peak = int'(dut.outstanding_q);
            if (m1.ack) acks++;
            if (m0.ack) m0_acks++;
            if (m1.stb && m1.stall) begin
                stall_cnt++;
                if (first_stall < 0) first_stall = sent;
            end
            if (m1.stb && !m1.stall) sent++;
            tick();
        end
        check("pw_acks", acks, 6);
        check("pw_peak", peak, 4);
        check("pw_first_stall", first_stall, 4);
        check("pw_stall_cnt", stall_cnt, 1);
        check("pw_m0_acks", m0_acks, 0);
        check("pw_final_outst", dut.outstanding_q, 0);
        m1.cyc = 0; m1.stb = 0;
        tick();
        tick();

        // m1 aborts with two outstanding
        m1.cyc = 1; m1.stb = 1;
        tick();
        tick();
        tick();
        m1.cyc = 0; m1.stb = 0;
        #1;
        check("ab_s_cyc", s.cyc, 0);
        check("ab_outst", dut.outstanding_q, 2);
        tick(); #1;
        check("ab_idle_outst", dut.outstanding_q, 0);
        check("ab_idle_state", dut.state_q, StIdle);
        fwd = 0;
        for (int k = 0; k < 4; k++) begin
            if (m0.ack || m1.ack || m0.err || m1.err) fwd++;
            tick(); #1;
        end
        check("ab_late_fwd", fwd, 0);

        // hung slave on an m0 read
        auto_ack = 0; s.ack = 0; pipe = '0;
        err_cnt = 0; err_first = -1;
        m0.cyc = 1; m0.stb = 1; m0.we = 0; m0.adr = 32'h200;
        tick();
        tick();
        m0.stb = 0;
        for (int w = 2; w < 25; w++) begin
            if (w == 22) m0.cyc = 0;
            #1;
            if (m0.err) begin
                err_cnt++;
                if (err_first < 0) err_first = w;
            end
`ifdef WB_ARB_TIMEOUT_EN
            if (w == 18) check("to_outst", dut.outstanding_q, 0);
            if (w == 20) begin
                check("to_abort_s_cyc", s.cyc, 0);
                check("to_abort_m0_stall", m0.stall, 1);
                check("to_abort_state", dut.state_q, StAbort);
            end
`else
            if (w == 18) check("hang_outst", dut.outstanding_q, 1);
            if (w == 20) begin
                check("hang_s_cyc", s.cyc, 1);
                check("hang_state", dut.state_q, StGnt0);
            end
`endif
            tick();
        end
        #1;
`ifdef WB_ARB_TIMEOUT_EN
        check("to_err_cnt", err_cnt, 1);
        check("to_err_window", err_first, 17);
`else
        check("hang_err_cnt", err_cnt, 0);
`endif
        check("to_end_state", dut.state_q, StIdle);

        // synchronous reset during a GNT1 burst with three outstanding
        auto_ack = 1; pipe = '0;
        m1.cyc = 1; m1.stb = 1; m1.we = 1; m1.adr = 32'h3000; m1.dat_m = 32'h55;
        tick();
        tick();
        tick();
        tick();
        m1.stb = 0;
        #1;
        check("mr_outst_pre", dut.outstanding_q, 3);
        rst_n = 0;
        tick();
        rst_n = 1; m1.cyc = 0;
        #1;
        check("mr_s_cyc", s.cyc, 0);
        check("mr_s_we", s.we, 0);
        check("mr_s_sel", s.sel, 0);
        check("mr_s_adr", s.adr, 0);
        check("mr_s_dat", s.dat_m, 0);
        check("mr_m1_stall", m1.stall, 1);
        check("mr_m0_stall", m0.stall, 1);
        check("mr_outst", dut.outstanding_q, 0);
        check("mr_state", dut.state_q, StIdle);
        check("mr_last_grant", dut.last_grant_q, 1);
        fwd = 0;
        for (int k = 0; k < 4; k++) begin
            if (m1.ack || m1.err || m0.ack || m0.err) fwd++;
            tick(); #1;
        end
        check("mr_no_resp", fwd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
